// File: rtl/riscv_mem_pkg.sv
// rtl/riscv_mem_pkg.sv - shared types and helpers for the unified memory arbiter
package riscv_mem_pkg;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_IF   = 2'd1,
    SRC_D    = 2'd2
  } mem_src_e;

  typedef struct packed {
    mem_src_e src;
    logic     we;
  } mem_tag_t;

  localparam int MEM_RD_LATENCY = 2;

  localparam mem_tag_t TAG_IDLE = '{src: SRC_NONE, we: 1'b0};

  // A flushed fetch keeps its SRAM slot but loses its destination.
  function automatic mem_tag_t flush_tag(input mem_tag_t t, input logic flush);
    mem_tag_t r;
    r = t;
    if (flush && (t.src == SRC_IF)) r.src = SRC_NONE;
    return r;
  endfunction

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// rtl/mem_arb_starve_ctr.sv - fetch starvation counter, used only when FAIR_ARB_EN is defined
module mem_arb_starve_ctr #(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic resetn,
  input  logic if_req_valid,
  input  logic if_req_ready,
  output logic force_if
);

  localparam logic [3:0] LIMIT_W = 4'(LIMIT);

  logic [3:0] count;

  // Count consecutive lost fetch cycles, saturating; any fetch grant clears it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count <= 4'd0;
    end else if (if_req_valid && if_req_ready) begin
      count <= 4'd0;
    end else if (if_req_valid && (count != LIMIT_W)) begin
      count <= count + 4'd1;
    end
  end

  assign force_if = (count == LIMIT_W);

endmodule

// File: rtl/unified_mem_arbiter.sv
// rtl/unified_mem_arbiter.sv - IF/D arbiter sharing one SRAM, fixed 2-cycle in-order responses; FAIR_ARB_EN enables anti-starvation
module unified_mem_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    if_req_valid,
  output logic                    if_req_ready,
  input  logic [ADDR_WIDTH-1:0]   if_addr,
  input  logic                    if_flush,
  output logic                    if_rsp_valid,
  output logic [DATA_WIDTH-1:0]   if_rsp_data,
  input  logic                    d_req_valid,
  output logic                    d_req_ready,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic                    d_we,
  input  logic [DATA_WIDTH/8-1:0] d_wmask,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  output logic                    d_rsp_valid,
  output logic [DATA_WIDTH-1:0]   d_rsp_data,
  output logic                    mem_en,
  output logic [DATA_WIDTH/8-1:0] mem_wmask,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
);

  localparam int MW = DATA_WIDTH / 8;

  if ((STARVE_LIMIT < 1) || (STARVE_LIMIT > 15)) begin : g_bad_limit
    $error("STARVE_LIMIT must be in 1..15");
  end

  logic     force_if;
  logic     d_grant;
  logic     if_grant;
  mem_tag_t s1_tag;
  mem_tag_t s2_tag;
  mem_tag_t s2_live;

`ifdef FAIR_ARB_EN
  mem_arb_starve_ctr #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve_ctr (
    .clk          (clk),
    .resetn       (resetn),
    .if_req_valid (if_req_valid),
    .if_req_ready (if_req_ready),
    .force_if     (force_if)
  );
`else
  assign force_if = 1'b0;
`endif

  // D has priority unless the fetch side has been starved long enough.
  assign d_req_ready  = resetn & ~force_if;
  assign if_req_ready = resetn & (~d_req_valid | force_if);
  assign d_grant      = d_req_valid & d_req_ready;
  assign if_grant     = if_req_valid & if_req_ready;

  // Stage 1: register the granted request and drive it onto the SRAM port.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_en    <= 1'b0;
      mem_addr  <= '0;
      mem_wmask <= '0;
      mem_wdata <= '0;
      s1_tag    <= TAG_IDLE;
    end else if (d_grant) begin
      mem_en    <= 1'b1;
      mem_addr  <= d_addr;
      mem_wmask <= d_we ? d_wmask : {MW{1'b0}};
      mem_wdata <= d_we ? d_wdata : {DATA_WIDTH{1'b0}};
      s1_tag    <= '{src: SRC_D, we: d_we};
    end else if (if_grant) begin
      mem_en    <= 1'b1;
      mem_addr  <= if_addr;
      mem_wmask <= '0;
      mem_wdata <= '0;
      s1_tag    <= '{src: SRC_IF, we: 1'b0};
    end else begin
      mem_en    <= 1'b0;
      mem_addr  <= '0;
      mem_wmask <= '0;
      mem_wdata <= '0;
      s1_tag    <= TAG_IDLE;
    end
  end

  // Stage 2: tag follows the SRAM read in flight; a flush drops fetch ownership.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s2_tag <= TAG_IDLE;
    end else begin
      s2_tag <= flush_tag(s1_tag, if_flush);
    end
  end

  // Tag of the read whose data is arriving now, after any same-cycle flush.
  always_comb begin
    s2_live = flush_tag(s2_tag, if_flush);
  end

  // Response stage: capture SRAM data and route it to the owning port.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      if_rsp_valid <= 1'b0;
      if_rsp_data  <= '0;
      d_rsp_valid  <= 1'b0;
      d_rsp_data   <= '0;
    end else begin
      if_rsp_valid <= (s2_live.src == SRC_IF);
      if_rsp_data  <= (s2_live.src == SRC_IF) ? mem_rdata : {DATA_WIDTH{1'b0}};
      d_rsp_valid  <= (s2_live.src == SRC_D);
      d_rsp_data   <= ((s2_live.src == SRC_D) && !s2_live.we) ? mem_rdata : {DATA_WIDTH{1'b0}};
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb/tb_unified_mem_arbiter.sv - self-checking bench for unified_mem_arbiter
module tb_unified_mem_arbiter;
  import riscv_mem_pkg::*;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        if_req_valid = 1'b0;
  logic        if_req_ready;
  logic [31:0] if_addr = '0;
  logic        if_flush = 1'b0;
  logic        if_rsp_valid;
  logic [31:0] if_rsp_data;
  logic        d_req_valid = 1'b0;
  logic        d_req_ready;
  logic [31:0] d_addr = '0;
  logic        d_we = 1'b0;
  logic [3:0]  d_wmask = '0;
  logic [31:0] d_wdata = '0;
  logic        d_rsp_valid;
  logic [31:0] d_rsp_data;
  logic        mem_en;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;

  always #5 clk = ~clk;

  unified_mem_arbiter #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk (clk), .resetn (resetn),
    .if_req_valid (if_req_valid), .if_req_ready (if_req_ready), .if_addr (if_addr),
    .if_flush (if_flush), .if_rsp_valid (if_rsp_valid), .if_rsp_data (if_rsp_data),
    .d_req_valid (d_req_valid), .d_req_ready (d_req_ready), .d_addr (d_addr),
    .d_we (d_we), .d_wmask (d_wmask), .d_wdata (d_wdata),
    .d_rsp_valid (d_rsp_valid), .d_rsp_data (d_rsp_data),
    .mem_en (mem_en), .mem_wmask (mem_wmask), .mem_addr (mem_addr),
    .mem_wdata (mem_wdata), .mem_rdata (mem_rdata)
  );

  function automatic logic [31:0] init_word(input int i);
    return (i == 16) ? 32'h0 : (32'h1000_0000 + i * 32'h0101_0103);
  endfunction

  // Behavioural single-port SRAM, 256 words.
  logic [31:0] sram [0:255];
  logic        sram_init = 1'b1;
  always @(posedge clk) begin
    if (sram_init) begin
      for (int i = 0; i < 256; i++) sram[i] <= init_word(i);
    end else if (mem_en) begin
      for (int b = 0; b < 4; b++)
        if (mem_wmask[b]) sram[mem_addr[9:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      mem_rdata <= sram[mem_addr[9:2]];
    end
  end

  // Reference model state.
  typedef struct { int due; logic is_d; logic [31:0] data; } exp_t;
  exp_t        q[$];
  logic [31:0] ref_mem [0:255];
  int          cyc = 0;
  int          starve = 0;
  int          checks = 0;
  int          errors = 0;

  logic        ifp = 0;  logic [31:0] ifa = 0;
  logic        dp = 0;   logic dwe = 0; logic [31:0] da = 0; logic [3:0] dm = 0; logic [31:0] dwd = 0;
  logic        fl = 0;

  int          n_if_rsp, n_d_rsp, n_if_grant, n_mem_en;
  logic [31:0] last_d_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive requests, check arbitration, advance model, check outputs.
  task automatic cycle();
    logic force_m, exp_dr, exp_ir, dg, ig, ev_if, ev_d;
    logic [31:0] ed_if, ed_d, wd;
    logic [3:0]  exp_wm;
    exp_t e;
    if_req_valid = ifp; if_addr = ifa; if_flush = fl;
    d_req_valid = dp; d_we = dwe; d_addr = da; d_wmask = dm; d_wdata = dwd;
`ifdef FAIR_ARB_EN
    force_m = (starve == LIMIT);
`else
    force_m = 1'b0;
`endif
    exp_dr = !force_m;
    exp_ir = !dp || force_m;
    dg = dp && exp_dr;
    ig = ifp && exp_ir;
    #1;
    chk("d_req_ready", {31'b0, d_req_ready}, {31'b0, exp_dr});
    chk("if_req_ready", {31'b0, if_req_ready}, {31'b0, exp_ir});
    if (if_req_valid && if_req_ready) n_if_grant++;
    @(posedge clk);
    cyc++;
    if (fl) begin
      for (int i = q.size() - 1; i >= 0; i--)
        if (!q[i].is_d && q[i].due >= cyc) q.delete(i);
    end
    if (ig) starve = 0;
    else if (ifp && !exp_ir && starve < LIMIT) starve++;
    exp_wm = 4'b0;
    if (dg) begin
      e.due = cyc + MEM_RD_LATENCY; e.is_d = 1'b1;
      e.data = dwe ? 32'h0 : ref_mem[da[9:2]];
      q.push_back(e);
      if (dwe) begin
        wd = ref_mem[da[9:2]];
        for (int b = 0; b < 4; b++) if (dm[b]) wd[b*8 +: 8] = dwd[b*8 +: 8];
        ref_mem[da[9:2]] = wd;
        exp_wm = dm;
      end
      dp = 0;
    end
    if (ig) begin
      e.due = cyc + MEM_RD_LATENCY; e.is_d = 1'b0; e.data = ref_mem[ifa[9:2]];
      q.push_back(e);
      ifp = 0;
    end
    ev_if = 0; ev_d = 0; ed_if = 0; ed_d = 0;
    while (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      if (e.is_d) begin ev_d = 1; ed_d = e.data; end
      else begin ev_if = 1; ed_if = e.data; end
    end
    #1;
    chk("mem_en", {31'b0, mem_en}, {31'b0, dg || ig});
    chk("mem_wmask", {28'b0, mem_wmask}, {28'b0, exp_wm});
    chk("if_rsp_valid", {31'b0, if_rsp_valid}, {31'b0, ev_if});
    chk("d_rsp_valid", {31'b0, d_rsp_valid}, {31'b0, ev_d});
    if (ev_if) chk("if_rsp_data", if_rsp_data, ed_if);
    if (ev_d) chk("d_rsp_data", d_rsp_data, ed_d);
    if (if_rsp_valid) n_if_rsp++;
    if (d_rsp_valid) begin n_d_rsp++; last_d_data = d_rsp_data; end
    if (mem_en) n_mem_en++;
    fl = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ready"}, {30'b0, if_req_ready, d_req_ready}, 32'h0);
    chk({tag, "_valids"}, {29'b0, mem_en, if_rsp_valid, d_rsp_valid}, 32'h0);
    chk({tag, "_mem"}, mem_addr | mem_wdata | {28'b0, mem_wmask}, 32'h0);
    chk({tag, "_rspdata"}, if_rsp_data | d_rsp_data, 32'h0);
  endtask

  task automatic clear_counts();
    n_if_rsp = 0; n_d_rsp = 0; n_if_grant = 0; n_mem_en = 0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    clear_counts();
    last_d_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    sram_init = 1'b0;
    resetn = 1'b1;

    // 1: back-to-back fetches
    clear_counts();
    ifp = 1; ifa = 32'h0; cycle();
    ifp = 1; ifa = 32'h4; cycle();
    ifp = 1; ifa = 32'h8; cycle();
    idle(4);
    chk("t1_if_rsp_cnt", n_if_rsp, 3);
    chk("t1_mem_en_cnt", n_mem_en, 3);
    chk("t1_d_rsp_cnt", n_d_rsp, 0);

    // 2: simultaneous, D wins first
    clear_counts();
    ifp = 1; ifa = 32'h100; dp = 1; dwe = 0; da = 32'h200; dm = 0; dwd = 0;
    cycle();
    cycle();
    idle(3);
    chk("t2_if_rsp_cnt", n_if_rsp, 1);
    chk("t2_d_rsp_cnt", n_d_rsp, 1);

    // 3: partial store then load
    dp = 1; dwe = 1; da = 32'h40; dm = 4'b0011; dwd = 32'hDEADBEEF; cycle();
    dp = 1; dwe = 0; da = 32'h40; dm = 0; dwd = 0; cycle();
    idle(3);
    chk("t3_load_data", last_d_data, 32'h0000BEEF);

    // 4: flush kills the accepted fetch, D unaffected
    clear_counts();
    ifp = 1; ifa = 32'h20; cycle();
    dp = 1; dwe = 0; da = 32'h80; fl = 1; cycle();
    idle(3);
    chk("t4_if_rsp_cnt", n_if_rsp, 0);
    chk("t4_d_rsp_cnt", n_d_rsp, 1);

    // 5: sustained contention
    clear_counts();
    ifa = 32'hC;
    for (int i = 0; i < 12; i++) begin
      ifp = 1;
      dp = 1; dwe = 0; da = 32'(i * 4);
      cycle();
    end
`ifdef FAIR_ARB_EN
    chk("t5_if_grants", n_if_grant, 2);
`else
    chk("t5_if_grants", n_if_grant, 0);
`endif
    idle(4);

    // 6: reset with requests in flight
    clear_counts();
    ifp = 1; ifa = 32'h10; cycle();
    dp = 1; dwe = 0; da = 32'h14;
    if_req_valid = 1; d_req_valid = 1;
    resetn = 1'b0;
    #1;
    check_all_zero("t6_rst");
    repeat (2) @(posedge clk);
    cyc += 2;
    #1;
    check_all_zero("t6_hold");
    q.delete();
    starve = 0;
    ifp = 0; dp = 0;
    resetn = 1'b1;
    idle(4);
    chk("t6_if_rsp_cnt", n_if_rsp, 0);
    chk("t6_d_rsp_cnt", n_d_rsp, 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      if (!ifp && ($urandom_range(1, 0) == 1)) begin
        ifp = 1; ifa = {22'b0, 8'($urandom_range(255, 0)), 2'b00};
      end
      if (!dp && ($urandom_range(1, 0) == 1)) begin
        dp = 1; dwe = 1'($urandom_range(1, 0));
        da = {22'b0, 8'($urandom_range(255, 0)), 2'b00};
        dm = 4'($urandom_range(15, 0)); dwd = $urandom;
      end
      fl = ($urandom_range(9, 0) == 0);
      cycle();
    end
    ifp = 0; dp = 0;
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
